// File: rtl/branch_resolver_pkg.sv
// branch_resolver_pkg
// Types and constants shared by the branch resolver and its helpers.
//   word        - 32-bit machine word used for PCs and targets
//   eq/ne/lt/ge - bit positions of the ALU compare flags in compare_async
//   cond_t      - branch condition selector carried with the instruction
//   br_state_t  - resolver FSM states
package branch_resolver_pkg;

  typedef logic [31:0] word;

  localparam int eq = 0;
  localparam int ne = 1;
  localparam int lt = 2;
  localparam int ge = 3;

  typedef enum logic [1:0] {
    COND_EQ = 2'd0,
    COND_NE = 2'd1,
    COND_LT = 2'd2,
    COND_GE = 2'd3
  } cond_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } br_state_t;

  // Picks the ALU flag that decides a conditional branch.
  function automatic logic select_flag(cond_t cond_sel, logic [3:0] flags);
    logic flag;
    flag = 1'b0;
    case (cond_sel)
      COND_EQ: flag = flags[eq];
      COND_NE: flag = flags[ne];
      COND_LT: flag = flags[lt];
      COND_GE: flag = flags[ge];
      default: flag = 1'b0;
    endcase
    return flag;
  endfunction

endpackage

// File: rtl/branch_resolver_sat_counter.sv
// sat_counter
// Saturating up-counter for performance statistics.
//   clock - rising-edge clock
//   reset - asynchronous active-high clear
//   inc   - count one event this cycle
//   count - current value, sticks at all-ones
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count events but never wrap: once every bit is set the value is frozen
  // so a long debug run cannot report a misleadingly small number.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// branch_resolver
// Stage-4 branch/jump resolution: compares the real outcome against the
// fetch prediction, issues a registered redirect and squashes the front end.
//   clock, reset        - clock and asynchronous active-high reset
//   stall               - pipeline stall, freezes resolution and the flush timer
//   valid               - stage-3 instruction present
//   is_branch, is_jump  - instruction kind (both high behaves as a jump)
//   cond                - which compare flag decides a branch
//   compare_async       - ALU compare flags
//   target, pc_plus4    - taken and fall-through PCs
//   pred_taken          - fetch predicted taken
//   pred_target         - fetch predicted target
//   redirect_valid      - one-cycle pulse telling fetch to load redirect_pc
//   redirect_pc         - corrected PC, held until the next redirect
//   flush               - squash stages 1..3
//   branch_count        - resolved branches and jumps (saturating)
//   mispredict_count    - resolved mispredictions (saturating)
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int FLUSH_STAGES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             valid,
  input  logic             is_branch,
  input  logic             is_jump,
  input  logic [1:0]       cond,
  input  logic [3:0]       compare_async,
  input  logic [31:0]      target,
  input  logic [31:0]      pc_plus4,
  input  logic             pred_taken,
  input  logic [31:0]      pred_target,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int FCW = (FLUSH_STAGES < 2) ? 1 : $clog2(FLUSH_STAGES + 1);
  localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_STAGES);

  br_state_t      state;
  logic [FCW-1:0] flush_left;
  logic           taken;
  logic           resolve;
  logic           mispredict;
  word            correct_pc;

  // Outcome of the instruction in stage 3. A jump is always taken, so an
  // instruction flagged as both branch and jump ignores the compare flags.
  // Resolution only happens in IDLE: during FLUSH the presented instruction
  // is wrong-path and must neither redirect nor be counted.
  always_comb begin
    taken      = is_jump | (is_branch & select_flag(cond_t'(cond), compare_async));
    resolve    = valid & (is_branch | is_jump) & ~stall & (state == IDLE);
    mispredict = resolve & ((taken != pred_taken) |
                            (taken & (target != pred_target)));
    correct_pc = taken ? target : pc_plus4;
  end

  // Redirect/flush sequencer. A mispredict fires a single redirect pulse and
  // loads the flush timer; flush then stays high until the timer has counted
  // FLUSH_STAGES unstalled cycles. The timer leaves FLUSH on the cycle it
  // reads 1, so flush drops exactly FLUSH_STAGES active cycles after the
  // redirect. Stalls hold the timer so squashed stages are not released early.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      flush_left     <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
    end else begin
      redirect_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (mispredict) begin
            redirect_valid <= 1'b1;
            redirect_pc    <= correct_pc;
            flush_left     <= FLUSH_LOAD;
            flush          <= 1'b1;
            state          <= FLUSH;
          end
        end
        FLUSH: begin
          if (!stall) begin
            if (flush_left == FCW'(1)) begin
              flush <= 1'b0;
              state <= IDLE;
            end else begin
              flush_left <= flush_left - FCW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          flush <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (resolve),
    .count (branch_count)
  );

  sat_counter #(.W(CNT_W)) u_mispredict_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (mispredict),
    .count (mispredict_count)
  );

endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver
// Scoreboard bench for branch_resolver: each driven cycle pushes the expected
// outputs for the following edge, which are popped and compared after it.
module tb_branch_resolver;

  localparam int FLUSH_N = 3;
  localparam int CW      = 4;
  localparam int CMAX    = (1 << CW) - 1;

  logic          clock;
  logic          reset;
  logic          stall;
  logic          valid;
  logic          is_branch;
  logic          is_jump;
  logic [1:0]    cond;
  logic [3:0]    compare_async;
  logic [31:0]   target;
  logic [31:0]   pc_plus4;
  logic          pred_taken;
  logic [31:0]   pred_target;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          flush;
  logic [CW-1:0] branch_count;
  logic [CW-1:0] mispredict_count;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        fl;
    int          bc;
    int          mc;
  } exp_t;

  exp_t sb[$];

  int assertCount;
  int failCount;

  int          mLeft;
  logic [31:0] mRpc;
  int          mBc;
  int          mMc;

  branch_resolver #(.FLUSH_STAGES(FLUSH_N), .CNT_W(CW)) dut (
    .clock            (clock),
    .reset            (reset),
    .stall            (stall),
    .valid            (valid),
    .is_branch        (is_branch),
    .is_jump          (is_jump),
    .cond             (cond),
    .compare_async    (compare_async),
    .target           (target),
    .pc_plus4         (pc_plus4),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .flush            (flush),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  // Free-running 10-unit clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // Drives one cycle of inputs, advances the reference model and queues the
  // outputs the DUT must show after the next rising edge; then pops and checks.
  task automatic applyStimulus(input string tag, input logic st, input logic v,
                               input logic br, input logic jp,
                               input logic [1:0] cd, input logic [3:0] flg,
                               input logic [31:0] tg, input logic [31:0] pc4,
                               input logic pt, input logic [31:0] ptg);
    logic tk, res, mis;
    exp_t e, got;
    @(negedge clock);
    stall = st; valid = v; is_branch = br; is_jump = jp; cond = cd;
    compare_async = flg; target = tg; pc_plus4 = pc4;
    pred_taken = pt; pred_target = ptg;

    tk  = jp | (br & flg[cd]);
    res = v & (br | jp) & ~st & (mLeft == 0);
    mis = res & ((tk != pt) | (tk & (tg != ptg)));
    if (mis) begin
      mRpc  = tk ? tg : pc4;
      mLeft = FLUSH_N;
    end else if ((mLeft != 0) && !st) begin
      mLeft--;
    end
    if (res && mBc < CMAX) mBc++;
    if (mis && mMc < CMAX) mMc++;
    e.rv = mis; e.rpc = mRpc; e.fl = (mLeft != 0); e.bc = mBc; e.mc = mMc;
    sb.push_back(e);

    @(posedge clock);
    #1;
    got = sb.pop_front();
    checkOutput({tag, ".redirect_valid"}, {31'b0, redirect_valid}, {31'b0, got.rv});
    checkOutput({tag, ".redirect_pc"}, redirect_pc, got.rpc);
    checkOutput({tag, ".flush"}, {31'b0, flush}, {31'b0, got.fl});
    checkOutput({tag, ".branch_count"}, 32'(branch_count), 32'(got.bc));
    checkOutput({tag, ".mispredict_count"}, 32'(mispredict_count), 32'(got.mc));
  endtask

  task automatic idleCycle(input string tag, input logic st);
    applyStimulus(tag, st, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic modelReset();
    mLeft = 0; mRpc = '0; mBc = 0; mMc = 0;
    sb.delete();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".redirect_valid"}, {31'b0, redirect_valid}, 32'h0);
    checkOutput({tag, ".redirect_pc"}, redirect_pc, 32'h0);
    checkOutput({tag, ".flush"}, {31'b0, flush}, 32'h0);
    checkOutput({tag, ".branch_count"}, 32'(branch_count), 32'h0);
    checkOutput({tag, ".mispredict_count"}, 32'(mispredict_count), 32'h0);
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    modelReset();
    reset = 1'b1; stall = 1'b0; valid = 1'b0; is_branch = 1'b0; is_jump = 1'b0;
    cond = 2'd0; compare_async = 4'h0; target = '0; pc_plus4 = '0;
    pred_taken = 1'b0; pred_target = '0;
    repeat (2) @(posedge clock);
    #1;
    checkAllZero("reset");
    @(negedge clock);
    reset = 1'b0;

    // Correctly predicted taken eq branch.
    applyStimulus("correct_eq", 0, 1, 1, 0, 2'd0, 4'b0101, 32'h100, 32'h14, 1, 32'h100);
    idleCycle("idle_a", 0);

    // lt not taken, predicted taken: redirect to fall-through, 3 flush cycles
    // with wrong-path branches presented that must not be counted.
    applyStimulus("mis_nt", 0, 1, 1, 0, 2'd2, 4'b1001, 32'h80, 32'h24, 1, 32'h80);
    for (int i = 0; i < FLUSH_N; i++)
      applyStimulus("flush_wp", 0, 1, 1, 0, 2'd1, 4'b0010, 32'h40, 32'h30, 0, 32'h0);
    idleCycle("after_flush", 0);

    // Jump to the wrong predicted target, with two stalls inside the flush.
    applyStimulus("mis_tgt", 0, 1, 0, 1, 2'd0, 4'h0, 32'h200, 32'h44, 1, 32'h1F0);
    applyStimulus("flush_st1", 1, 1, 1, 0, 2'd0, 4'b0001, 32'h60, 32'h48, 0, 32'h0);
    applyStimulus("flush_st2", 1, 1, 1, 0, 2'd0, 4'b0001, 32'h60, 32'h48, 0, 32'h0);
    for (int i = 0; i < FLUSH_N; i++)
      applyStimulus("flush_run", 0, 1, 0, 1, 2'd0, 4'h0, 32'h70, 32'h4C, 0, 32'h0);
    idleCycle("idle_b", 0);

    // Branch and jump both high acts as a jump even with the flag clear.
    applyStimulus("both_hi", 0, 1, 1, 1, 2'd0, 4'b0000, 32'h300, 32'h54, 0, 32'h0);
    for (int i = 0; i < FLUSH_N; i++) idleCycle("flush_c", 0);

    // Mispredicting branch held by a stall, then released.
    applyStimulus("stall_res1", 1, 1, 1, 0, 2'd3, 4'b1000, 32'h400, 32'h58, 0, 32'h0);
    applyStimulus("stall_res2", 1, 1, 1, 0, 2'd3, 4'b1000, 32'h400, 32'h58, 0, 32'h0);
    applyStimulus("stall_rel", 0, 1, 1, 0, 2'd3, 4'b1000, 32'h400, 32'h58, 0, 32'h0);
    idleCycle("flush_d", 0);

    // Asynchronous reset in the middle of the flush.
    #2;
    reset = 1'b1;
    #1;
    checkAllZero("async_rst");
    modelReset();
    @(negedge clock);
    reset = 1'b0;
    applyStimulus("post_rst", 0, 1, 1, 0, 2'd1, 4'b0010, 32'h500, 32'h5C, 1, 32'h500);

    // Saturation: enough correct predictions to exceed the counter range.
    for (int i = 0; i < CMAX + 3; i++)
      applyStimulus("sat", 0, 1, 1, 0, 2'd0, 4'b0000, 32'h600, 32'h60, 0, 32'h0);

    // Random traffic against the model, counters already saturated for branches.
    for (int i = 0; i < 40; i++)
      applyStimulus("rand", ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
                    $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
                    2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                    32'h800 + 32'($urandom_range(0, 3) * 4),
                    32'h64 + 32'(i * 4), $urandom_range(0, 1),
                    32'h800 + 32'($urandom_range(0, 3) * 4));

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
